vrf_banked_regfile: RTL and testbench

- Parametrised vector register file: NUM_REGS registers of VLEN bits, each split into LANE_W lanes; the datapath stage that follows decode reads it.
- Inputs: one lane-masked single write port, one dual-result pair write port (low/high result to any even/odd register pair), two registered read ports.
- A built-in clear engine zeroes the array one register per cycle after reset or on request, with a busy flag back to the controller.

---
 rtl/vrf_pkg.sv | 54 +++++
 rtl/vrf_banked_regfile_if.sv | 48 ++++
 rtl/vrf_clear_ctrl.sv | 83 ++++++++
 rtl/vrf_banked_regfile.sv | 123 ++++++++++++
 tb/tb_vrf_banked_regfile.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_pkg.sv
// ---------------------------------------------------------------------------
// vrf_pkg
// Shared definitions for the banked vector register file:
//   - default geometry (VLEN / LANE_W / NUM_REGS)
//   - clear-engine FSM state type
//   - lane_merge(): per-lane select between the old and new register value
// ---------------------------------------------------------------------------
package vrf_pkg;

  localparam int VRF_VLEN     = 512;
  localparam int VRF_LANE_W   = 32;
  localparam int VRF_NUM_REGS = 16;

  // lane_merge works on a fixed maximum width so it can serve any
  // register-file geometry; callers zero-extend in and truncate out.
  // Supports VLEN up to 1024 bits with lanes of at least 8 bits.
  localparam int MERGE_MAX_VLEN  = 1024;
  localparam int MERGE_MAX_LANES = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vrf_state_e;

  // Lanes whose mask bit is set take new_v, the rest keep old_v.
  // The mask is consumed LSB-first by shifting, so no variable bit
  // selects are needed; lanes past the real lane count see zero mask bits.
  function automatic logic [MERGE_MAX_VLEN-1:0] lane_merge(
    input logic [MERGE_MAX_VLEN-1:0]  old_v,
    input logic [MERGE_MAX_VLEN-1:0]  new_v,
    input logic [MERGE_MAX_LANES-1:0] mask,
    input int                         lane_w
  );
    logic [MERGE_MAX_VLEN-1:0]  lane_ones;
    logic [MERGE_MAX_VLEN-1:0]  bit_mask;
    logic [MERGE_MAX_LANES-1:0] m;
    int                         shift;
    lane_ones = (MERGE_MAX_VLEN'(1) << lane_w) - MERGE_MAX_VLEN'(1);
    bit_mask  = {MERGE_MAX_VLEN{1'b0}};
    m         = mask;
    shift     = 0;
    for (int l = 0; l < MERGE_MAX_LANES; l++) begin
      if (m[0]) begin
        bit_mask = bit_mask | (lane_ones << shift);
      end else begin
        bit_mask = bit_mask;
      end
      m     = m >> 1;
      shift = shift + lane_w;
    end
    return (old_v & ~bit_mask) | (new_v & bit_mask);
  endfunction

endpackage

// File: rtl/vrf_banked_regfile_if.sv
// ---------------------------------------------------------------------------
// vrf_banked_regfile_if
// Bus bundle between the controller (master) and the register file (slave).
//   clr_req / clr_busy            : clear request and clear-engine busy flag
//   wr_en/wr_addr/wr_data/wr_lane_mask : lane-masked single write port
//   pair_wr_en/pair_idx/pair_lo_data/pair_hi_data : even/odd pair write port
//   rd_addr1/2, rd_data1/2        : two registered read ports
//   wr_conflict                   : single and pair write hit the same register
// ---------------------------------------------------------------------------
interface vrf_banked_regfile_if #(
  parameter int VLEN     = vrf_pkg::VRF_VLEN,
  parameter int LANE_W   = vrf_pkg::VRF_LANE_W,
  parameter int NUM_REGS = vrf_pkg::VRF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
);
  localparam int LANES = VLEN / LANE_W;

  logic              clr_req;
  logic              clr_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [LANES-1:0]  wr_lane_mask;
  logic              pair_wr_en;
  logic [AW-2:0]     pair_idx;
  logic [VLEN-1:0]   pair_lo_data;
  logic [VLEN-1:0]   pair_hi_data;
  logic [AW-1:0]     rd_addr1;
  logic [AW-1:0]     rd_addr2;
  logic [VLEN-1:0]   rd_data1;
  logic [VLEN-1:0]   rd_data2;
  logic              wr_conflict;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, wr_lane_mask,
           pair_wr_en, pair_idx, pair_lo_data, pair_hi_data,
           rd_addr1, rd_addr2,
    input  clr_busy, rd_data1, rd_data2, wr_conflict
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, wr_lane_mask,
           pair_wr_en, pair_idx, pair_lo_data, pair_hi_data,
           rd_addr1, rd_addr2,
    output clr_busy, rd_data1, rd_data2, wr_conflict
  );

endinterface

// File: rtl/vrf_clear_ctrl.sv
// ---------------------------------------------------------------------------
// vrf_clear_ctrl
// Clear engine: walks clr_idx from 0 to NUM_REGS-1, one register per cycle.
// Starts in CLEAR out of reset and on clr_req while IDLE; clr_req during a
// running clear is ignored.
//   clk, rst_n  : clock, async active-low reset
//   clr_req     : one-cycle clear request
//   clr_active  : engine is in CLEAR (array writes/reads are overridden)
//   clr_idx     : register zeroed on this cycle's edge
//   clr_busy    : registered busy flag for the controller
// ---------------------------------------------------------------------------
module vrf_clear_ctrl
  import vrf_pkg::*;
#(
  parameter int NUM_REGS = VRF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_active,
  output logic [AW-1:0] clr_idx,
  output logic          clr_busy
);

  vrf_state_e    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_busy_q, clr_busy_d;

  // Next-state, index and busy computation for the clear FSM.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_idx_d  = {AW{1'b0}};
          clr_busy_d = 1'b1;
        end else begin
          state_d    = IDLE;
          clr_busy_d = 1'b0;
        end
      end
      CLEAR: begin
        // Busy drops on the same edge that zeroes the last register.
        if (clr_idx_q == {AW{1'b1}}) begin
          state_d    = IDLE;
          clr_idx_d  = {AW{1'b0}};
          clr_busy_d = 1'b0;
        end else begin
          state_d    = CLEAR;
          clr_idx_d  = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
          clr_busy_d = 1'b1;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_idx_d  = {AW{1'b0}};
        clr_busy_d = 1'b1;
      end
    endcase
  end

  // FSM state registers; reset restarts the clear from register 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= {AW{1'b0}};
      clr_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign clr_active = (state_q == CLEAR);
  assign clr_idx    = clr_idx_q;
  assign clr_busy   = clr_busy_q;

endmodule

// File: rtl/vrf_banked_regfile.sv
// ---------------------------------------------------------------------------
// vrf_banked_regfile
// NUM_REGS x VLEN vector register file with a lane-masked single write port,
// an even/odd pair write port, two registered read ports and a built-in
// clear engine (vrf_clear_ctrl).
//   clk, rst_n : clock, async active-low reset (array itself is not reset;
//                the clear engine zeroes it after reset release)
//   bus        : vrf_banked_regfile_if.slave (see interface for signals)
// Write priority: the pair port overrides the single port on the same
// register and raises wr_conflict for one cycle.
// Optional build macro VRF_BYPASS_EN: reads forward same-cycle writes.
// ---------------------------------------------------------------------------
module vrf_banked_regfile
  import vrf_pkg::*;
#(
  parameter int VLEN     = VRF_VLEN,
  parameter int LANE_W   = VRF_LANE_W,
  parameter int NUM_REGS = VRF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vrf_banked_regfile_if.slave  bus
);

  logic            clr_active_s;
  logic [AW-1:0]   clr_idx_s;
  logic            clr_busy_s;
  logic [VLEN-1:0] merged_s;
  logic [VLEN-1:0] mem_q_s [NUM_REGS];
  logic [VLEN-1:0] mem_d_s [NUM_REGS];
  logic [VLEN-1:0] rd_data1_q, rd_data1_d;
  logic [VLEN-1:0] rd_data2_q, rd_data2_d;
  logic            wr_conflict_q, wr_conflict_d;

  vrf_clear_ctrl #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (bus.clr_req),
    .clr_active (clr_active_s),
    .clr_idx    (clr_idx_s),
    .clr_busy   (clr_busy_s)
  );

  // Single-port write value: masked lanes from wr_data, others from the array.
  always_comb begin
    merged_s = VLEN'(lane_merge(MERGE_MAX_VLEN'(mem_q_s[bus.wr_addr]),
                                MERGE_MAX_VLEN'(bus.wr_data),
                                MERGE_MAX_LANES'(bus.wr_lane_mask),
                                LANE_W));
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [VLEN-1:0] reg_q, reg_d;

    // Per-register next value: clear beats everything, pair beats single.
    always_comb begin
      if (clr_active_s) begin
        if (clr_idx_s == AW'(r)) begin
          reg_d = {VLEN{1'b0}};
        end else begin
          reg_d = reg_q;
        end
      end else if (bus.pair_wr_en && (bus.pair_idx == (AW-1)'(r / 2))) begin
        reg_d = ((r % 2) == 0) ? bus.pair_lo_data : bus.pair_hi_data;
      end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
        reg_d = merged_s;
      end else begin
        reg_d = reg_q;
      end
    end

    // Register storage; contents are defined only after the clear engine runs.
    always_ff @(posedge clk) begin
      reg_q <= reg_d;
    end

    assign mem_q_s[r] = reg_q;
    assign mem_d_s[r] = reg_d;
  end

  // Read data and conflict flag for the next cycle; forced to 0 while clearing.
  always_comb begin
    if (clr_active_s) begin
      rd_data1_d    = {VLEN{1'b0}};
      rd_data2_d    = {VLEN{1'b0}};
      wr_conflict_d = 1'b0;
    end else begin
`ifdef VRF_BYPASS_EN
      // The next-state array already carries merge and pair priority.
      rd_data1_d    = mem_d_s[bus.rd_addr1];
      rd_data2_d    = mem_d_s[bus.rd_addr2];
`else
      rd_data1_d    = mem_q_s[bus.rd_addr1];
      rd_data2_d    = mem_q_s[bus.rd_addr2];
`endif
      wr_conflict_d = bus.wr_en && bus.pair_wr_en &&
                      (bus.wr_addr[AW-1:1] == bus.pair_idx);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1_q    <= {VLEN{1'b0}};
      rd_data2_q    <= {VLEN{1'b0}};
      wr_conflict_q <= 1'b0;
    end else begin
      rd_data1_q    <= rd_data1_d;
      rd_data2_q    <= rd_data2_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.rd_data1    = rd_data1_q;
  assign bus.rd_data2    = rd_data2_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.clr_busy    = clr_busy_s;

endmodule

// File: tb/tb_vrf_banked_regfile.sv
// ---------------------------------------------------------------------------
// tb_vrf_banked_regfile
// Directed scenarios plus randomized traffic for vrf_banked_regfile. A
// behavioural model (plain array + clear counter) predicts the outputs after
// every rising edge; directed steps add hand-computed literal expectations.
// Honors VRF_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_vrf_banked_regfile;

  localparam int VLEN  = 512;
  localparam int LW    = 32;
  localparam int NR    = 16;
  localparam int LANES = VLEN / LW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vrf_banked_regfile_if bus ();

  vrf_banked_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [VLEN-1:0] mdl [NR];
  bit              clearing = 1'b1;
  int              clr_cnt  = 0;
  logic [VLEN-1:0] exp_rd1, exp_rd2;
  logic            exp_conf, exp_busy;

  always @(posedge clk) begin : model_cmp
    logic [VLEN-1:0] pre [NR];
    int wa, pl, ra1, ra2;
    if (!rst_n) begin
      clearing = 1'b1;
      clr_cnt  = 0;
      exp_rd1  = '0;
      exp_rd2  = '0;
      exp_conf = 1'b0;
    end else if (clearing) begin
      mdl[clr_cnt] = '0;
      clr_cnt++;
      if (clr_cnt == NR) clearing = 1'b0;
      exp_rd1  = '0;
      exp_rd2  = '0;
      exp_conf = 1'b0;
    end else begin
      pre = mdl;
      wa  = int'(bus.wr_addr);
      pl  = int'(bus.pair_idx);
      ra1 = int'(bus.rd_addr1);
      ra2 = int'(bus.rd_addr2);
      exp_conf = bus.wr_en && bus.pair_wr_en && (wa / 2 == pl);
      if (bus.wr_en) begin
        for (int l = 0; l < LANES; l++)
          if (bus.wr_lane_mask[l]) mdl[wa][l*LW +: LW] = bus.wr_data[l*LW +: LW];
      end
      if (bus.pair_wr_en) begin
        mdl[2*pl]   = bus.pair_lo_data;
        mdl[2*pl+1] = bus.pair_hi_data;
      end
`ifdef VRF_BYPASS_EN
      exp_rd1 = mdl[ra1];
      exp_rd2 = mdl[ra2];
`else
      exp_rd1 = pre[ra1];
      exp_rd2 = pre[ra2];
`endif
      if (bus.clr_req) begin
        clearing = 1'b1;
        clr_cnt  = 0;
      end
    end
    exp_busy = clearing;
    #1;
    check("mdl_rd_data1", bus.rd_data1, exp_rd1);
    check("mdl_rd_data2", bus.rd_data2, exp_rd2);
    check("mdl_wr_conflict", VLEN'(bus.wr_conflict), VLEN'(exp_conf));
    check("mdl_clr_busy", VLEN'(bus.clr_busy), VLEN'(exp_busy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.clr_req      = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.wr_lane_mask = '0;
    bus.pair_wr_en   = 1'b0;
    bus.pair_idx     = '0;
    bus.pair_lo_data = '0;
    bus.pair_hi_data = '0;
  endtask

  function automatic logic [VLEN-1:0] rnd512();
    logic [VLEN-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LW +: LW] = $urandom;
    return v;
  endfunction

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (bus.clr_busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  logic [VLEN-1:0] v_a5, v_ff, v_11, v_22, v_33, v_44, v_55, v_66, v_77, v_99, v_exp;
  int cnt;

  initial begin
    v_a5 = {64{8'hA5}}; v_ff = {64{8'hFF}}; v_11 = {64{8'h11}}; v_22 = {64{8'h22}};
    v_33 = {64{8'h33}}; v_44 = {64{8'h44}}; v_55 = {64{8'h55}}; v_66 = {64{8'h66}};
    v_77 = {64{8'h77}}; v_99 = {64{8'h99}};
    idle_inputs();
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_data1", bus.rd_data1, '0);
    check("reset_wr_conflict", VLEN'(bus.wr_conflict), '0);
    rst_n = 1'b1;
    check("busy_at_release", VLEN'(bus.clr_busy), VLEN'(1));
    wait_clear(cnt);
    check("clear_length", VLEN'(cnt), VLEN'(16));

    // every register reads zero after the clear
    for (int r = 0; r < NR; r++) begin
      bus.rd_addr1 = 4'(r);
      bus.rd_addr2 = 4'(NR - 1 - r);
      @(negedge clk);
      check("post_clear_rd1", bus.rd_data1, '0);
      check("post_clear_rd2", bus.rd_data2, '0);
    end

    // full-mask write of reg3
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = v_a5; bus.wr_lane_mask = 16'hFFFF;
    @(negedge clk);
    idle_inputs(); bus.rd_addr1 = 4'd3;
    @(negedge clk);
    check("reg3_a5", bus.rd_data1, v_a5);

    // single-lane write of reg3
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = v_ff; bus.wr_lane_mask = 16'h0001;
    @(negedge clk);
    idle_inputs(); bus.rd_addr1 = 4'd3;
    @(negedge clk);
    v_exp = {{60{8'hA5}}, 32'hFFFF_FFFF};
    check("reg3_lane0", bus.rd_data1, v_exp);

    // pair write idx 5 -> reg10/reg11
    bus.pair_wr_en = 1'b1; bus.pair_idx = 3'd5; bus.pair_lo_data = v_11; bus.pair_hi_data = v_22;
    @(negedge clk);
    idle_inputs(); bus.rd_addr1 = 4'd10; bus.rd_addr2 = 4'd11;
    @(negedge clk);
    check("pair_reg10", bus.rd_data1, v_11);
    check("pair_reg11", bus.rd_data2, v_22);

    // conflicting single and pair writes on reg4
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = v_33; bus.wr_lane_mask = 16'hFFFF;
    bus.pair_wr_en = 1'b1; bus.pair_idx = 3'd2; bus.pair_lo_data = v_44; bus.pair_hi_data = v_55;
    @(negedge clk);
    check("conflict_pulse", VLEN'(bus.wr_conflict), VLEN'(1));
    idle_inputs(); bus.rd_addr1 = 4'd4; bus.rd_addr2 = 4'd5;
    @(negedge clk);
    check("conflict_drop", VLEN'(bus.wr_conflict), '0);
    check("conflict_reg4", bus.rd_data1, v_44);
    check("conflict_reg5", bus.rd_data2, v_55);

    // clear with writes attempted while it runs
    bus.clr_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("clear_busy_up", VLEN'(bus.clr_busy), VLEN'(1));
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = v_77; bus.wr_lane_mask = 16'hFFFF;
    @(negedge clk);
    idle_inputs();
    bus.pair_wr_en = 1'b1; bus.pair_idx = 3'd0; bus.pair_lo_data = v_66; bus.pair_hi_data = v_66;
    bus.clr_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    wait_clear(cnt);
    check("clear2_bounded", VLEN'(cnt < 100), VLEN'(1));
    bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd0;
    @(negedge clk);
    check("dropped_reg7", bus.rd_data1, '0);
    check("dropped_reg0", bus.rd_data2, '0);
    bus.rd_addr1 = 4'd1; bus.rd_addr2 = 4'd3;
    @(negedge clk);
    check("dropped_reg1", bus.rd_data1, '0);
    check("cleared_reg3", bus.rd_data2, '0);

    // same-cycle write and read in IDLE
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = v_99; bus.wr_lane_mask = 16'hFFFF;
    bus.pair_wr_en = 1'b1; bus.pair_idx = 3'd1; bus.pair_lo_data = v_66; bus.pair_hi_data = v_77;
    bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd3;
    @(negedge clk);
`ifdef VRF_BYPASS_EN
    check("bypass_single", bus.rd_data1, v_99);
    check("bypass_pair", bus.rd_data2, v_77);
`else
    check("nobypass_single", bus.rd_data1, '0);
    check("nobypass_pair", bus.rd_data2, '0);
`endif
    idle_inputs();
    @(negedge clk);
    check("after_reg7", bus.rd_data1, v_99);
    check("after_reg3", bus.rd_data2, v_77);

    // reset in the middle of a clear restarts it from index 0
    bus.clr_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midclr_reset_busy", VLEN'(bus.clr_busy), VLEN'(1));
    check("midclr_reset_rd2", bus.rd_data2, '0);
    rst_n = 1'b1;
    wait_clear(cnt);
    check("restart_clear_length", VLEN'(cnt), VLEN'(16));

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      bus.clr_req      = ($urandom_range(0, 63) == 0);
      bus.wr_en        = $urandom_range(0, 1);
      bus.wr_addr      = 4'($urandom_range(0, NR - 1));
      bus.wr_data      = rnd512();
      case ($urandom_range(0, 3))
        0:       bus.wr_lane_mask = 16'hFFFF;
        1:       bus.wr_lane_mask = 16'h0000;
        default: bus.wr_lane_mask = 16'($urandom);
      endcase
      bus.pair_wr_en   = ($urandom_range(0, 2) == 0);
      bus.pair_idx     = 3'($urandom_range(0, NR / 2 - 1));
      bus.pair_lo_data = rnd512();
      bus.pair_hi_data = rnd512();
      bus.rd_addr1     = 4'($urandom_range(0, NR - 1));
      bus.rd_addr2     = ($urandom_range(0, 3) == 0) ? bus.rd_addr1 : 4'($urandom_range(0, NR - 1));
      @(negedge clk);
    end

    idle_inputs();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
